nios2_subsystem_fifo_read_ctrl: RTL and testbench

NIOS2_SUBSYSTEM_FIFO_READ_CTRL -- requirements
Module: nios2_subsystem_fifo_read_ctrl

---
 rtl/nios2_subsystem_pkg.sv | 32 +++
 rtl/nios2_subsystem_fifo_read_ctrl.sv | 148 ++++++++++++++
 tb/tb_nios2_subsystem_fifo_read_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_subsystem_pkg.sv
// Shared register map, bit positions and FSM encoding for the sample FIFO read controller.
package nios2_subsystem_pkg;

    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_DATA    = 2'd3;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_VALID_BIT = 1;
    localparam int STAT_DONE_BIT  = 2;
    localparam int STAT_REM_LSB   = 8;

    localparam int COUNT_W = 8;
    localparam int REM_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // A programmed count of zero stands for the full 256-sample burst.
    function automatic logic [REM_W-1:0] burst_len(input logic [COUNT_W-1:0] count);
        return (count == '0) ? 9'd256 : {1'b0, count};
    endfunction

endpackage

// File: rtl/nios2_subsystem_fifo_read_ctrl.sv
// Avalon-MM slave that pops a programmed burst of samples from a FIFO, one at a time,
// holding each in a DATA register until the CPU reads it.
//
// state | meaning
// IDLE  | no burst active; waits for start
// ISSUE | burst active; pops one word once FIFO has data and DATA is free
// WAIT  | pop issued last cycle; captures fifo_q and decrements remaining
module nios2_subsystem_fifo_read_ctrl
    import nios2_subsystem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic              fifo_rdreq,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty
);

    state_e              state_q, state_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [REM_W-1:0]    remaining_q, remaining_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                data_valid_q, data_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic wr_en, rd_en, ctrl_wr, start_cmd, abort_cmd, busy;
    logic unused_wdata;

    assign wr_en     = chipselect & ~write_n;
    assign rd_en     = chipselect & ~read_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CONTROL);
    assign start_cmd = ctrl_wr & writedata[CTRL_START_BIT];
    assign abort_cmd = ctrl_wr & writedata[CTRL_ABORT_BIT];
    assign busy      = (state_q != ST_IDLE);
    assign irq       = done_q & irq_en_q;

    assign unused_wdata = ^writedata[31:COUNT_W];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        remaining_d  = remaining_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        data_valid_d = data_valid_q;
        data_d       = data_q;
        fifo_rdreq   = 1'b0;

        if (ctrl_wr) begin
            irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        end
        if (wr_en && (address == ADDR_COUNT)) begin
            count_d = writedata[COUNT_W-1:0];
        end
        if (wr_en && (address == ADDR_STATUS)) begin
            done_d = 1'b0;
        end
        if (rd_en && (address == ADDR_DATA) && data_valid_q) begin
            data_valid_d = 1'b0;
        end

        // Abort beats start; the capture below overrides a coincident DATA-read clear.
        case (state_q)
            ST_IDLE: begin
                if (abort_cmd) begin
                    remaining_d = '0;
                end else if (start_cmd) begin
                    remaining_d = burst_len(count_q);
                    done_d      = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort_cmd) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else if (!fifo_empty && !data_valid_q) begin
                    fifo_rdreq = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_cmd) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    data_d       = fifo_q;
                    data_valid_d = 1'b1;
                    remaining_d  = remaining_q - 9'd1;
                    if (remaining_q == 9'd1) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            remaining_q  <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            remaining_q  <= remaining_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CONTROL: readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            ADDR_COUNT:   readdata[COUNT_W-1:0] = count_q;
            ADDR_STATUS: begin
                readdata[STAT_BUSY_BIT]              = busy;
                readdata[STAT_VALID_BIT]             = data_valid_q;
                readdata[STAT_DONE_BIT]              = done_q;
                readdata[STAT_REM_LSB +: REM_W]      = remaining_q;
            end
            default:      readdata = 32'(data_q);
        endcase
    end

endmodule

// File: tb/tb_nios2_subsystem_fifo_read_ctrl.sv
// Directed bench for the FIFO read controller: bus tasks, a small FIFO model and
// hand-computed STATUS/DATA expectations.
module tb_nios2_subsystem_fifo_read_ctrl;

    localparam int DATA_W = 16;
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_CNT  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_DATA = 2'd3;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] fifo_q = '0;
    logic              fifo_empty;

    nios2_subsystem_fifo_read_ctrl #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .fifo_rdreq (fifo_rdreq),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    // FIFO model: words pushed by the stimulus, popped on fifo_rdreq, data one cycle later.
    logic [DATA_W-1:0] mem [0:1023];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   pop_cnt = 0;
    int   viol = 0;
    logic force_empty = 1'b0;
    logic flush = 1'b0;
    logic prev_rdreq = 1'b0;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rdreq) begin
            if (fifo_empty || prev_rdreq) viol <= viol + 1;
            fifo_q  <= mem[rd_ptr[9:0]];
            pop_cnt <= pop_cnt + 1;
        end
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rdreq && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
        prev_rdreq <= fifo_rdreq;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr++;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                               input int budget, input string tag);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < budget; i++) begin
            bus_read(A_STAT, s);
            if ((s & mask) == val) break;
        end
        check(tag, s & mask, val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]       r;
        logic [DATA_W-1:0] v3 [3];
        int                p0;

        v3[0] = 16'hA1A1; v3[1] = 16'hB2B2; v3[2] = 16'hC3C3;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0;
        write_n = 1'b1; read_n = 1'b1; writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 check("reset readdata", readdata, 32'h0);
        end
        check("reset irq", {31'b0, irq}, 32'h0);
        check("reset rdreq", {31'b0, fifo_rdreq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // COUNT register keeps bits 7:0 only
        bus_write(A_CNT, 32'h0000_01FF);
        bus_read(A_CNT, r);  check("count 8-bit", r, 32'hFF);
        bus_read(A_CTRL, r); check("control idle", r, 32'h0);

        // Three-sample burst, CPU drains each sample
        bus_write(A_CNT, 32'd3);
        foreach (v3[i]) push(v3[i]);
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            wait_status(32'h2, 32'h2, 20, "b3 valid");
            bus_read(A_DATA, r);
            check("b3 data", r, {16'h0, v3[i]});
        end
        wait_status(ALL, 32'h4, 10, "b3 final status");
        check("b3 pops", 32'(pop_cnt - p0), 32'd3);

        // Two-sample burst stalls while DATA is unread
        bus_write(A_CNT, 32'd2);
        push(16'h1111); push(16'h2222);
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h1);
        idle(20);
        check("b2 stall pops", 32'(pop_cnt - p0), 32'd1);
        bus_read(A_STAT, r); check("b2 stall status", r, 32'h103);
        bus_read(A_DATA, r); check("b2 data0", r, 32'h1111);
        wait_status(ALL, 32'h6, 20, "b2 done+valid");
        check("b2 pops", 32'(pop_cnt - p0), 32'd2);
        bus_read(A_DATA, r); check("b2 data1", r, 32'h2222);
        bus_read(A_STAT, r); check("b2 status", r, 32'h4);

        // Four-sample burst held off by an empty FIFO
        bus_write(A_CNT, 32'd4);
        force_empty = 1'b1;
        for (int i = 0; i < 4; i++) push(16'(16'h4000 + i));
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h1);
        idle(10);
        check("b4 empty pops", 32'(pop_cnt - p0), 32'd0);
        bus_read(A_STAT, r); check("b4 empty status", r, 32'h401);
        force_empty = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_status(32'h2, 32'h2, 20, "b4 valid");
            bus_read(A_DATA, r);
            check("b4 data", r, 32'(16'h4000 + i));
        end
        wait_status(ALL, 32'h4, 10, "b4 final status");
        check("b4 pops", 32'(pop_cnt - p0), 32'd4);

        // COUNT=0 means a 256-sample burst
        bus_write(A_CNT, 32'd0);
        bus_read(A_CNT, r); check("count zero", r, 32'h0);
        for (int i = 0; i < 256; i++) push(16'(16'hE000 + i));
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STAT, r); check("b256 initial status", r, 32'h10001);
        for (int i = 0; i < 256; i++) begin
            wait_status(32'h2, 32'h2, 20, "b256 valid");
            bus_read(A_DATA, r);
            check("b256 data", r, 32'(16'hE000 + i));
        end
        wait_status(ALL, 32'h4, 10, "b256 final status");
        check("b256 pops", 32'(pop_cnt - p0), 32'd256);

        // Interrupt follows done AND irq_en; STATUS write clears done
        bus_write(A_CTRL, 32'h4);
        bus_read(A_CTRL, r); check("control irq_en", r, 32'h4);
        check("irq with old done", {31'b0, irq}, 32'h1);
        bus_write(A_STAT, 32'h0);
        check("irq after status wr", {31'b0, irq}, 32'h0);
        bus_write(A_CNT, 32'd1);
        push(16'h3636);
        bus_write(A_CTRL, 32'h5);
        wait_status(ALL, 32'h6, 20, "b1 done+valid");
        check("b1 irq", {31'b0, irq}, 32'h1);
        bus_read(A_DATA, r); check("b1 data", r, 32'h3636);
        bus_write(A_STAT, 32'h0);
        check("b1 irq cleared", {31'b0, irq}, 32'h0);

        // Abort while stalled in ISSUE keeps the held sample
        bus_write(A_CNT, 32'd5);
        for (int i = 0; i < 5; i++) push(16'(16'h5000 + i));
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h5);
        idle(10);
        bus_read(A_STAT, r); check("abort pre status", r, 32'h403);
        bus_write(A_CTRL, 32'h6);
        bus_read(A_STAT, r); check("abort status", r, 32'h2);
        check("abort irq", {31'b0, irq}, 32'h0);
        bus_read(A_DATA, r); check("abort held data", r, 32'h5000);
        check("abort pops", 32'(pop_cnt - p0), 32'd1);
        do_flush();

        // Abort landing in WAIT discards the popped word
        bus_write(A_CNT, 32'd1);
        push(16'h7777);
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h5);
        bus_write(A_CTRL, 32'h6);
        bus_read(A_STAT, r); check("abort wait status", r, 32'h0);
        check("abort wait pops", 32'(pop_cnt - p0), 32'd1);

        // Start and abort together: abort wins
        push(16'h8888);
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h3);
        idle(3);
        bus_read(A_STAT, r); check("start+abort status", r, 32'h0);
        check("start+abort pops", 32'(pop_cnt - p0), 32'd0);
        do_flush();

        // Reset asserted during WAIT
        bus_write(A_CNT, 32'd3);
        for (int i = 0; i < 3; i++) push(16'(16'h9000 + i));
        p0 = pop_cnt;
        bus_write(A_CTRL, 32'h1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst rdreq", {31'b0, fifo_rdreq}, 32'h0);
        check("rst irq", {31'b0, irq}, 32'h0);
        address = A_STAT;
        #1 check("rst status", readdata, 32'h0);
        address = A_CNT;
        #1 check("rst count", readdata, 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(10);
        check("rst pops", 32'(pop_cnt - p0), 32'd1);
        bus_read(A_STAT, r); check("rst post status", r, 32'h0);

        check("rdreq protocol", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
